// File: rtl/commit_bus_arbiter_pkg.sv
// Shared commit-bus definitions: packet geometry and field positions.
// The arbiter never looks inside a packet; field positions are here for its consumers.
package commit_bus_arbiter_pkg;

    localparam int COMMIT_RSID_W = 4;
    localparam int COMMIT_DST_W  = 7;
    localparam int COMMIT_DATA_W = 32;

    localparam int COMMIT_PACKET_SIZE     = COMMIT_RSID_W + 1 + COMMIT_DST_W + 3 * COMMIT_DATA_W;
    localparam int MOD_COMMIT_PACKET_SIZE = COMMIT_PACKET_SIZE + 1;
    localparam int COMMIT_VALID_BIT       = MOD_COMMIT_PACKET_SIZE - 1;

    // Field layout, MSB first: {RSID, WE, DST, X, Y, Z}
    localparam int COMMIT_Z_LSB    = 0;
    localparam int COMMIT_Y_LSB    = COMMIT_Z_LSB + COMMIT_DATA_W;
    localparam int COMMIT_X_LSB    = COMMIT_Y_LSB + COMMIT_DATA_W;
    localparam int COMMIT_DST_LSB  = COMMIT_X_LSB + COMMIT_DATA_W;
    localparam int COMMIT_WE_BIT   = COMMIT_DST_LSB + COMMIT_DST_W;
    localparam int COMMIT_RSID_LSB = COMMIT_WE_BIT + 1;

endpackage

// File: rtl/commit_bus_arbiter_rr_priority_encoder.sv
// Combinational round-robin priority encoder: first set request at or after
// the pointer, wrapping modulo the vector width.
module rr_priority_encoder #(
    parameter int NUM_STATIONS = 8,
    parameter int PTR_W        = 3
) (
    input  logic [NUM_STATIONS-1:0] iRequest,
    input  logic [PTR_W-1:0]        iPointer,
    output logic [PTR_W-1:0]        oWinner,
    output logic                    oFound
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        oWinner = '0;
        oFound  = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_STATIONS; k++) begin
            sum = {1'b0, iPointer} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_STATIONS)) begin
                sum = sum - (PTR_W+1)'(NUM_STATIONS);
            end
            idx = sum[PTR_W-1:0];
            if (!oFound && iRequest[idx]) begin
                oWinner = idx;
                oFound  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/commit_bus_arbiter.sv
// Round-robin commit bus arbiter: one registered grant pulse and bus broadcast
// per cycle, chosen among stations whose request is not already being granted.
module commit_bus_arbiter
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = 8,
    parameter int PTR_W        = 3
) (
    input  logic                                       Clock,
    input  logic                                       Reset,
    input  logic [NUM_STATIONS-1:0]                    iCommitRequest,
    input  logic [NUM_STATIONS*COMMIT_PACKET_SIZE-1:0] iCommitData,
    input  logic                                       iStall,
    output logic [NUM_STATIONS-1:0]                    oCommitGranted,
    output logic [MOD_COMMIT_PACKET_SIZE-1:0]          oCommitBus,
    output logic [PTR_W-1:0]                           oArbPointer
);

    logic [PTR_W-1:0]        rrPtr;
    logic [NUM_STATIONS-1:0] eligible;
    logic [PTR_W-1:0]        winner;
    logic                    found;
    logic [NUM_STATIONS-1:0] winnerOneHot;
    logic [PTR_W-1:0]        ptrNext;
    logic                    doGrant;

    // A station being granted this cycle still holds its request; mask it.
    assign eligible = iCommitRequest & ~oCommitGranted;

    rr_priority_encoder #(
        .NUM_STATIONS (NUM_STATIONS),
        .PTR_W        (PTR_W)
    ) uEncoder (
        .iRequest (eligible),
        .iPointer (rrPtr),
        .oWinner  (winner),
        .oFound   (found)
    );

    assign doGrant = found && !iStall;

    always_comb begin
        winnerOneHot         = '0;
        winnerOneHot[winner] = 1'b1;
        if (winner == PTR_W'(NUM_STATIONS - 1)) begin
            ptrNext = '0;
        end else begin
            ptrNext = winner + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rrPtr          <= '0;
            oCommitGranted <= '0;
            oCommitBus     <= '0;
        end else if (doGrant) begin
            rrPtr          <= ptrNext;
            oCommitGranted <= winnerOneHot;
            oCommitBus     <= {1'b1, iCommitData[winner*COMMIT_PACKET_SIZE +: COMMIT_PACKET_SIZE]};
        end else begin
            oCommitGranted                <= '0;
            oCommitBus[COMMIT_VALID_BIT]  <= 1'b0;
        end
    end

    assign oArbPointer = rrPtr;

endmodule

// File: tb/tb_commit_bus_arbiter.sv
// Directed table-driven bench for commit_bus_arbiter: per-cycle vectors of
// inputs with the expected winner, bus contents and round-robin pointer.
module tb_commit_bus_arbiter;
    import commit_bus_arbiter_pkg::*;

    localparam int N  = 8;
    localparam int PW = 3;

    logic                              Clock;
    logic                              Reset;
    logic [N-1:0]                      iCommitRequest;
    logic [N*COMMIT_PACKET_SIZE-1:0]   iCommitData;
    logic                              iStall;
    logic [N-1:0]                      oCommitGranted;
    logic [MOD_COMMIT_PACKET_SIZE-1:0] oCommitBus;
    logic [PW-1:0]                     oArbPointer;

    commit_bus_arbiter #(.NUM_STATIONS(N), .PTR_W(PW)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iCommitRequest (iCommitRequest),
        .iCommitData    (iCommitData),
        .iStall         (iStall),
        .oCommitGranted (oCommitGranted),
        .oCommitBus     (oCommitBus),
        .oArbPointer    (oArbPointer)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic         rstN;
        logic         stall;
        logic [N-1:0] req;
        int           expWin;   // -1: no grant expected
        logic [PW-1:0] expPtr;
    } vec_t;

    vec_t vecs[$];
    logic [COMMIT_PACKET_SIZE-1:0] pkt [N];
    logic [COMMIT_PACKET_SIZE-1:0] lastPayload;
    logic [MOD_COMMIT_PACKET_SIZE-1:0] expBus;
    logic [N-1:0] expGrant;
    int total;
    int bad;

    function automatic vec_t mk(logic rstN, logic stall, logic [N-1:0] req, int expWin, logic [PW-1:0] expPtr);
        vec_t v;
        v.rstN = rstN; v.stall = stall; v.req = req; v.expWin = expWin; v.expPtr = expPtr;
        return v;
    endfunction

    task automatic check_vec(input int i);
        vec_t v;
        v = vecs[i];
        expGrant = (v.expWin < 0) ? '0 : N'(1 << v.expWin);
        if (!v.rstN) lastPayload = '0;
        if (v.expWin >= 0) begin
            lastPayload = pkt[v.expWin];
            expBus = {1'b1, pkt[v.expWin]};
        end else begin
            expBus = {1'b0, lastPayload};
        end
        total++;
        if (oCommitGranted !== expGrant) begin
            bad++;
            $display("FAIL vec%0d grant: got %h want %h", i, oCommitGranted, expGrant);
        end
        total++;
        if (oCommitBus !== expBus) begin
            bad++;
            $display("FAIL vec%0d bus: got %h want %h", i, oCommitBus, expBus);
        end
        total++;
        if (oArbPointer !== v.expPtr) begin
            bad++;
            $display("FAIL vec%0d ptr: got %0d want %0d", i, oArbPointer, v.expPtr);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        lastPayload = '0;
        Reset = 1'b0;
        iStall = 1'b0;
        iCommitRequest = '0;

        // Distinct packet per station; station 3 carries X = 0x0001_0000.
        for (int s = 0; s < N; s++) begin
            logic [31:0] x;
            x = 32'h0000_2000 << s;
            pkt[s] = {4'(s), 1'b1, 7'(s + 8), x, ~x, 32'h0101_0101 * 32'(s)};
            iCommitData[s*COMMIT_PACKET_SIZE +: COMMIT_PACKET_SIZE] = pkt[s];
        end

        // Reset state
        vecs.push_back(mk(0, 0, 8'h00, -1, 0));
        // Single request: station 3 from cycle 5
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 8'h00, -1, 0));
        vecs.push_back(mk(1, 0, 8'h08,  3, 4));
        vecs.push_back(mk(1, 0, 8'h08, -1, 4));
        vecs.push_back(mk(1, 0, 8'h00, -1, 4));
        // Simultaneous 1,4,6 from ptr 0; each drops the edge after its grant
        vecs.push_back(mk(0, 0, 8'h00, -1, 0));
        vecs.push_back(mk(1, 0, 8'h52,  1, 2));
        vecs.push_back(mk(1, 0, 8'h52,  4, 5));
        vecs.push_back(mk(1, 0, 8'h50,  6, 7));
        vecs.push_back(mk(1, 0, 8'h40, -1, 7));
        vecs.push_back(mk(1, 0, 8'h00, -1, 7));
        // Wrap and fairness: bring ptr to 5, then all stations request
        vecs.push_back(mk(0, 0, 8'h00, -1, 0));
        vecs.push_back(mk(1, 0, 8'h10,  4, 5));
        vecs.push_back(mk(1, 0, 8'h10, -1, 5));
        for (int k = 0; k < 16; k++) vecs.push_back(mk(1, 0, 8'hFF, (5 + k) % 8, PW'((6 + k) % 8)));
        vecs.push_back(mk(1, 0, 8'h00, -1, 5));
        // Stall with stations 2 and 7 pending
        vecs.push_back(mk(0, 0, 8'h00, -1, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 1, 8'h84, -1, 0));
        vecs.push_back(mk(1, 0, 8'h84,  2, 3));
        vecs.push_back(mk(1, 0, 8'h84,  7, 0));
        vecs.push_back(mk(1, 0, 8'h80, -1, 0));
        vecs.push_back(mk(1, 0, 8'h00, -1, 0));
        // Stall arriving while a grant is on the bus
        vecs.push_back(mk(1, 0, 8'h02,  1, 2));
        vecs.push_back(mk(1, 1, 8'h02, -1, 2));
        vecs.push_back(mk(1, 0, 8'h00, -1, 2));
        // Reset while station 6's grant is on the bus
        vecs.push_back(mk(1, 0, 8'h40,  6, 7));
        vecs.push_back(mk(0, 0, 8'h40, -1, 0));
        vecs.push_back(mk(1, 0, 8'h00, -1, 0));
        // Same station back-to-back: grants two cycles apart
        vecs.push_back(mk(1, 0, 8'h01,  0, 1));
        vecs.push_back(mk(1, 0, 8'h01, -1, 1));
        vecs.push_back(mk(1, 0, 8'h01,  0, 1));
        vecs.push_back(mk(1, 0, 8'h01, -1, 1));
        vecs.push_back(mk(1, 0, 8'h00, -1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clock);
            Reset          = vecs[i].rstN;
            iStall         = vecs[i].stall;
            iCommitRequest = vecs[i].req;
            @(posedge Clock);
            #1;
            check_vec(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_bus_arbiter.md
# commit_bus_arbiter

Consumes the commit requests of all execution stations (sqrt, add, mul, div, logic, ...) and, once per cycle, picks one to broadcast on the shared commit bus. The broadcast feeds the register file write port and every reservation station's operand-capture logic. Arbitration is round-robin, so no station starves. Grant and bus data are registered and appear in the same cycle.

## Interface
- NUM_STATIONS, default 8: number of requesting stations; station index equals its RSID (iId).
- PTR_W, default 3: width of the round-robin pointer; equals clog2(NUM_STATIONS).
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- iCommitRequest  in  NUM_STATIONS  per-station request; bit i driven by station i's oCommitResquest.
- iCommitData  in  NUM_STATIONS*`COMMIT_PACKET_SIZE  flattened packets; station i occupies slice [i*`COMMIT_PACKET_SIZE +: `COMMIT_PACKET_SIZE].
- iStall  in  1  register-file/back-end stall; while high, no new grant is issued.
- oCommitGranted  out  NUM_STATIONS  one-hot grant pulse; bit i wired to station i's iCommitGranted.
- oCommitBus  out  `MOD_COMMIT_PACKET_SIZE  registered broadcast: {valid bit, winning `COMMIT_PACKET_SIZE packet}, with valid as the MSB.

## Operation
- Eligible set in cycle t: iCommitRequest & ~oCommitGranted. A station granted in cycle t still holds its request that cycle, so it is masked to prevent a double grant.
- Arbitration uses a round-robin priority encoder. Search starts at pointer ptr and wraps modulo NUM_STATIONS. The first eligible index found is the winner w.
- If iStall is low and the eligible set is non-empty:
  - next cycle: oCommitGranted = onehot(w);
  - next cycle: oCommitBus = {1'b1, iCommitData slice w as sampled in cycle t};
  - ptr <= (w+1) mod NUM_STATIONS.
- Otherwise:
  - next cycle: oCommitGranted = 0;
  - next cycle: oCommitBus valid = 0, and the payload holds its last value;
  - ptr is unchanged.
- Station contract: request and data are held stable from assertion until the cycle the grant is seen. The request is dropped on the following edge.
- Packet fields (RSID, WE, destination, X/Y/Z) pass through unmodified. The arbiter does not inspect them.
- No request with no grant for more than NUM_STATIONS arbitration cycles while iStall is low; this is a starvation bound.

## Timing
- Reset (Reset==0 at an edge):
  - oCommitGranted = 0;
  - oCommitBus = 0, valid included;
  - ptr = 0, so station 0 has highest priority.
- Latency: request sampled at edge t, grant and bus valid during cycle t+1. Each grant is exactly a 1-cycle pulse.
- Throughput: one commit per cycle across distinct stations. The same station can commit at most every 2 cycles.
- iStall sampled at edge t blocks the grant for cycle t+1. A grant already on the bus in cycle t completes regardless.
- Reset mid-operation: any in-flight grant or valid is cleared the next cycle. Stations must themselves reset; the arbiter does not replay lost grants.
- Pointer wrap: after a grant to station NUM_STATIONS-1, ptr = 0.
- Request de-asserted in the same cycle it would win: the winner is computed only from the sampled inputs, so no grant is issued to that station.

## Structure
- Shared header aDefinitions.v holds:
  - `COMMIT_PACKET_SIZE and `MOD_COMMIT_PACKET_SIZE;
  - `COMMIT_VALID_BIT (= `MOD_COMMIT_PACKET_SIZE-1);
  - the existing `COMMIT_RSID_RNG, `COMMIT_WE_RNG, `COMMIT_DST_RNG and `X/Y/Z_RNG.
- One sub-module: rr_priority_encoder (inputs: request vector, pointer; outputs: winner index, found). It is purely combinational, so it can be reused by the issue-side arbiter.
- Top level holds:
  - the pointer register;
  - the grant register;
  - the bus register;
  - the packet mux, indexed slice select by w.

## Test plan
- Single request: station 3 requests with X=0x0001_0000 from cycle 5. Required: oCommitGranted=0x08 in cycle 6 only, bus valid=1 carrying X=0x0001_0000, ptr=4.
- Simultaneous requests: stations 1, 4 and 6 request together with ptr=0. Required: grants 0x02, 0x10, 0x40 in consecutive cycles, each station dropping its request after its grant, with no duplicate grants.
- Wrap and fairness: all 8 stations hold requests continuously, re-asserting after each grant, with ptr=5. Required: grant order 5,6,7,0,1,2,3,4, repeating, and no station waits more than 8 cycles.
- Stall: stations 2 and 7 request, with iStall high for 4 cycles. Required: no grant and valid=0 during the stall; first grant (station 2) the cycle after iStall falls.
- Reset mid-operation: Reset driven low during the cycle a grant to station 6 is on the bus. Required: the next cycle has oCommitGranted=0, oCommitBus=0 and ptr=0.
- Same-station back-to-back: station 0 re-asserts immediately after its grant with no other requesters. Required: grants in cycles t+1 and t+3, never in two adjacent cycles.
